// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI link.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [7:0] {
        SQI_CMD_WRITE = 8'h02,
        SQI_CMD_READ  = 8'h03
    } sqi_cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD,
        WR,
        ERR
    } sqi_mem_state_t;

    localparam int unsigned SQI_ADDR_NIBBLES  = 6;
    localparam int unsigned SQI_DUMMY_NIBBLES = 2;

endpackage

// File: rtl/idli_sqi_ram_m.sv
// Byte array behind the SQI responder: async read, SQI write port and backdoor write port.
module idli_sqi_ram_m #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_data
);

    logic [7:0] mem [2**ADDR_W];

    assign rd_data = mem[rd_addr];

    // SQI port takes priority when both ports hit the same byte.
    always_ff @(posedge clk) begin
        if (bd_we && !(wr_en && (wr_addr == bd_addr))) begin
            mem[bd_addr] <= bd_data;
        end
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI serial SRAM responder: decodes READ/WRITE, 24-bit address and data nibbles
// from the core's SQI link and serves bytes from an internal RAM.
module idli_sqi_mem_m
    import idli_pkg::*;
#(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              i_mem_gck,
    input  logic              i_mem_rst,
    input  logic              i_mem_sck,
    input  logic              i_mem_cs,
    input  sqi_data_t         i_mem_sio,
    output sqi_data_t         o_mem_sio,
    output logic              o_mem_sio_oe,
    input  logic              i_mem_bd_we,
    input  logic [ADDR_W-1:0] i_mem_bd_addr,
    input  logic [7:0]        i_mem_bd_data
);

    sqi_mem_state_t    state;
    logic [2:0]        cnt;
    logic              is_rd;
    logic [23:0]       shift;
    logic [23:0]       shift_nxt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [3:0]        wr_hi;
    logic              beat;
    logic              sqi_we;

    assign beat      = ~i_mem_cs & i_mem_sck;
    assign shift_nxt = {shift[19:0], i_mem_sio};
    assign addr_inc  = addr + ADDR_W'(1);

    // On a low-nibble read beat the next high nibble comes from the following byte.
    assign rd_addr = (state == RD && cnt[0]) ? addr_inc : addr;
    assign sqi_we  = beat && (state == WR) && cnt[0];

    idli_sqi_ram_m #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (i_mem_gck),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (sqi_we),
        .wr_addr (addr),
        .wr_data ({wr_hi, i_mem_sio}),
        .bd_we   (i_mem_bd_we),
        .bd_addr (i_mem_bd_addr),
        .bd_data (i_mem_bd_data)
    );

    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state        <= IDLE;
            cnt          <= '0;
            is_rd        <= 1'b0;
            shift        <= '0;
            addr         <= '0;
            wr_hi        <= '0;
            o_mem_sio    <= '0;
            o_mem_sio_oe <= 1'b0;
        end else if (i_mem_cs) begin
            state        <= IDLE;
            cnt          <= '0;
            o_mem_sio_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= CMD;
                    cnt   <= '0;
                end
                CMD: if (beat) begin
                    shift <= shift_nxt;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd1) begin
                        cnt <= '0;
                        case (sqi_cmd_t'(shift_nxt[7:0]))
                            SQI_CMD_READ:  begin state <= ADDR; is_rd <= 1'b1; end
                            SQI_CMD_WRITE: begin state <= ADDR; is_rd <= 1'b0; end
                            default:       state <= ERR;
                        endcase
                    end
                end
                ADDR: if (beat) begin
                    shift <= shift_nxt;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'(SQI_ADDR_NIBBLES - 1)) begin
                        cnt   <= '0;
                        addr  <= shift_nxt[ADDR_W-1:0];
                        state <= is_rd ? DUMMY : WR;
                    end
                end
                DUMMY: if (beat) begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'(SQI_DUMMY_NIBBLES - 1)) begin
                        cnt          <= '0;
                        o_mem_sio    <= rd_data[7:4];
                        o_mem_sio_oe <= 1'b1;
                        state        <= RD;
                    end
                end
                RD: if (beat) begin
                    if (!cnt[0]) begin
                        o_mem_sio <= rd_data[3:0];
                        cnt       <= 3'd1;
                    end else begin
                        o_mem_sio <= rd_data[7:4];
                        addr      <= addr_inc;
                        cnt       <= '0;
                    end
                end
                WR: if (beat) begin
                    if (!cnt[0]) begin
                        wr_hi <= i_mem_sio;
                        cnt   <= 3'd1;
                    end else begin
                        addr <= addr_inc;
                        cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed self-checking bench for the SQI memory responder.
module tb_idli_sqi_mem_m;

    localparam int unsigned ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic              sck;
    logic              cs;
    logic [3:0]        sio_in;
    logic [3:0]        sio_out;
    logic              oe;
    logic              bd_we;
    logic [ADDR_W-1:0] bd_addr;
    logic [7:0]        bd_data;

    int vectors = 0;
    int errors  = 0;
    int stall_mode = 0;
    int beat_n = 0;

    idli_sqi_mem_m #(
        .ADDR_W (ADDR_W)
    ) dut (
        .i_mem_gck     (clk),
        .i_mem_rst     (rst),
        .i_mem_sck     (sck),
        .i_mem_cs      (cs),
        .i_mem_sio     (sio_in),
        .o_mem_sio     (sio_out),
        .o_mem_sio_oe  (oe),
        .i_mem_bd_we   (bd_we),
        .i_mem_bd_addr (bd_addr),
        .i_mem_bd_data (bd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [3:0] n);
        int stall;
        stall = (stall_mode != 0) ? (beat_n % 4) : 0;
        beat_n++;
        sck    = 1'b1;
        sio_in = n;
        tick();
        sck = 1'b0;
        repeat (stall) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        beat(b[7:4]);
        beat(b[3:0]);
    endtask

    task automatic start();
        cs  = 1'b0;
        sck = 1'b0;
        tick();
    endtask

    task automatic stop();
        cs  = 1'b1;
        sck = 1'b0;
        tick();
        chk("oe_after_cs", {7'd0, oe}, 8'h00);
    endtask

    task automatic hdr(input logic [7:0] cmd, input logic [23:0] a);
        start();
        send_byte(cmd);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic wr(input logic [23:0] a, input logic [15:0] d, input int nb);
        hdr(8'h02, a);
        for (int i = 0; i < nb; i++) send_byte(d[(nb-1-i)*8 +: 8]);
        stop();
    endtask

    task automatic rd(input string tag, input logic [23:0] a, input logic [23:0] d, input int nb);
        logic [3:0] exp;
        hdr(8'h03, a);
        beat(4'h0);
        beat(4'h0);
        for (int i = 0; i < 2*nb; i++) begin
            exp = d[(2*nb-1-i)*4 +: 4];
            chk(tag, {4'h0, sio_out}, {4'h0, exp});
            chk({tag, "_oe"}, {7'd0, oe}, 8'h01);
            if (i != 2*nb-1) beat(4'h0);
        end
        stop();
    endtask

    task automatic bd_wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        tick(); tick();
        chk("rst_oe", {7'd0, oe}, 8'h00);
        chk("rst_sio", {4'h0, sio_out}, 8'h00);
        rst = 1'b0;
        tick();

        bd_wr(17'h1FFFF, 8'h11);
        bd_wr(17'h00000, 8'h22);
        bd_wr(17'h00011, 8'hC7);

        // write then read back
        wr(24'h000100, 16'hA53C, 2);
        rd("wr_rd", 24'h000100, 24'h00A53C, 2);

        // address wrap
        rd("wrap", 24'h01FFFF, 24'h001122, 2);

        // high address bits alias
        wr(24'hFE0003, 16'h0077, 1);
        rd("alias", 24'h000003, 24'h000077, 1);

        // partial byte discarded on cs high
        hdr(8'h02, 24'h000010);
        beat(4'hB); beat(4'hE); beat(4'hF);
        stop();
        rd("abort", 24'h000010, 24'h00BEC7, 2);

        // bad command: no output, no writes
        start();
        send_byte(8'h05);
        chk("bad_oe0", {7'd0, oe}, 8'h00);
        send_byte(8'h02);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
        send_byte(8'h55);
        chk("bad_oe1", {7'd0, oe}, 8'h00);
        stop();
        rd("bad_nowr", 24'h000010, 24'h00BEC7, 2);

        // reset in the middle of a read
        hdr(8'h03, 24'h000100);
        beat(4'h0); beat(4'h0);
        chk("mid_pre_oe", {7'd0, oe}, 8'h01);
        beat(4'h0);
        rst = 1'b1;
        tick(); tick();
        chk("mid_rst_oe", {7'd0, oe}, 8'h00);
        chk("mid_rst_sio", {4'h0, sio_out}, 8'h00);
        rst = 1'b0;
        stop();
        rd("post_rst", 24'h000101, 24'h00003C, 1);

        // simultaneous SQI and backdoor writes
        hdr(8'h02, 24'h000300);
        beat(4'h1);
        bd_we = 1'b1; bd_addr = 17'h00300; bd_data = 8'hEE;
        beat(4'h2);
        bd_we = 1'b0;
        beat(4'h3);
        bd_we = 1'b1; bd_addr = 17'h00302; bd_data = 8'h99;
        beat(4'h4);
        bd_we = 1'b0;
        stop();
        rd("dual", 24'h000300, 24'h123499, 3);

        // stalled beats
        stall_mode = 1;
        rd("stall_rd", 24'h000100, 24'h00A53C, 2);
        wr(24'h000200, 16'h5AC3, 2);
        rd("stall_wr", 24'h000200, 24'h005AC3, 2);
        stall_mode = 0;
        rd("nostall", 24'h000200, 24'h005AC3, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
